fetch_decouple_queue: RTL and testbench

//  Decoupling FIFO between IF and ID. Receives the PC and Instruction produced by
//  the IF stage, buffers up to DEPTH entries, and presents them in order to the ID

---
 rtl/fetch_decouple_queue_pkg.sv | 10 +
 rtl/fetch_queue_mem.sv | 26 ++
 rtl/fetch_decouple_queue.sv | 94 +++++++++
 tb/tb_fetch_decouple_queue.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_decouple_queue_pkg.sv
// Shared defaults for the IF/ID decoupling queue: data width, queue depth
// and the instruction word presented to ID when the queue is empty.
package fetch_decouple_queue_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module fetch_queue_mem #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/fetch_decouple_queue.sv
// In-order FIFO between IF and ID. Freezes IF when full and discards every
// buffered entry (plus the incoming wrong-path one) on branch_taken.
module fetch_decouple_queue
    import fetch_decouple_queue_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [WIDTH-1:0] if_pc,
    input  logic [WIDTH-1:0] if_instruction,
    output logic             freeze,
    input  logic             branch_taken,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_instruction,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]     count_reg, count_next;
    logic               full;
    logic               enq;
    logic               deq;
    logic [2*WIDTH-1:0] head_entry;

    // Full is decoded from the registered count only, so freeze never depends
    // combinationally on ID's ready; a dequeue cannot make room in the same cycle.
    assign full     = (count_reg == FULL_COUNT);
    assign freeze   = full;
    assign id_valid = (count_reg != '0);
    assign enq      = if_valid & ~full & ~branch_taken;
    assign deq      = id_valid & id_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (branch_taken) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (enq) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
                2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    fetch_queue_mem #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (enq),
        .wr_addr (wr_ptr_reg),
        .wr_data ({if_pc, if_instruction}),
        .rd_addr (rd_ptr_reg),
        .rd_data (head_entry)
    );

    // Unwritten (unreset) slots are never exposed: empty forces constants.
    assign id_pc          = id_valid ? head_entry[2*WIDTH-1:WIDTH] : '0;
    assign id_instruction = id_valid ? head_entry[WIDTH-1:0] : WIDTH'(NOP_INSTR);
    assign count          = count_reg;

endmodule

// File: tb/tb_fetch_decouple_queue.sv
// Directed bench for fetch_decouple_queue: reset, fill, drain, streaming,
// flush and a wrap-around run with random ID stalls against a small queue model.
module tb_fetch_decouple_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_valid;
    logic [WIDTH-1:0] if_pc;
    logic [WIDTH-1:0] if_instruction;
    logic             freeze;
    logic             branch_taken;
    logic             id_ready;
    logic             id_valid;
    logic [WIDTH-1:0] id_pc;
    logic [WIDTH-1:0] id_instruction;
    logic [2:0]       count;

    int errors = 0;
    int checks = 0;

    fetch_decouple_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] mk_instr(input logic [WIDTH-1:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] pc, input logic br, input logic rdy);
        if_valid       = v;
        if_pc          = pc;
        if_instruction = mk_instr(pc);
        branch_taken   = br;
        id_ready       = rdy;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] pc;
        int sent;
        int recv;
        int cyc;
        logic will_enq;
        logic will_deq;

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_freeze", 64'(freeze), 64'd0);
        check("rst_id_pc", 64'(id_pc), 64'd0);
        check("rst_id_instr", 64'(id_instruction), 64'd0);
        tick();
        rst = 1'b1;

        // Reset asserted mid-run while three entries are held
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        check("pre_rst_count", 64'(count), 64'd3);
        check("pre_rst_head", 64'(id_pc), 64'h200);
        #2 rst = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_valid", 64'(id_valid), 64'd0);
        check("async_rst_freeze", 64'(freeze), 64'd0);
        check("async_rst_id_pc", 64'(id_pc), 64'd0);
        tick();
        rst = 1'b1;

        // Fill to DEPTH, then a 5th entry must be refused
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'(4 * (i + 1)), 1'b0, 1'b0);
            tick();
            check("fill_count", 64'(count), 64'(i + 1));
            check("fill_freeze", 64'(freeze), 64'(i == DEPTH - 1));
        end
        drive(1'b1, 32'd20, 1'b0, 1'b0);
        tick();
        check("full_count", 64'(count), 64'd4);
        check("full_freeze", 64'(freeze), 64'd1);
        check("full_head", 64'(id_pc), 64'd4);

        // Drain in order; pc 20 must not appear
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_valid", 64'(id_valid), 64'd1);
            check("drain_pc", 64'(id_pc), 64'(4 * (i + 1)));
            check("drain_instr", 64'(id_instruction), 64'(mk_instr(32'(4 * (i + 1)))));
            tick();
        end
        check("drained_valid", 64'(id_valid), 64'd0);
        check("drained_pc", 64'(id_pc), 64'd0);
        check("drained_count", 64'(count), 64'd0);

        // Streaming: one-cycle latency, occupancy steady at 1
        for (int i = 0; i < 10; i++) begin
            pc = 32'h1000 + 32'(4 * i);
            drive(1'b1, pc, 1'b0, 1'b1);
            tick();
            check("stream_count", 64'(count), 64'd1);
            check("stream_pc", 64'(id_pc), 64'(pc));
            check("stream_freeze", 64'(freeze), 64'd0);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("stream_end_count", 64'(count), 64'd0);

        // Flush with a concurrent wrong-path entry
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        check("pre_flush_count", 64'(count), 64'd3);
        drive(1'b1, 32'd40, 1'b1, 1'b0);
        tick();
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(id_valid), 64'd0);
        drive(1'b1, 32'd100, 1'b0, 1'b0);
        tick();
        check("post_flush_head", 64'(id_pc), 64'd100);
        check("post_flush_count", 64'(count), 64'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("post_flush_drain", 64'(count), 64'd0);

        // Wrap: 3*DEPTH entries through the queue with random ID stalls
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 3 * DEPTH && cyc < 400) begin
            pc = 32'h2000 + 32'(4 * sent);
            drive(sent < 3 * DEPTH, pc, 1'b0, 1'($urandom_range(0, 1)));
            will_enq = if_valid && (exp_q.size() < DEPTH);
            will_deq = id_ready && (exp_q.size() != 0);
            check("wrap_count", 64'(count), 64'(exp_q.size()));
            check("wrap_freeze", 64'(freeze), 64'(exp_q.size() == DEPTH));
            if (exp_q.size() != 0) begin
                check("wrap_head", 64'(id_pc), 64'(exp_q[0]));
            end
            tick();
            if (will_deq) begin
                void'(exp_q.pop_front());
                recv++;
            end
            if (will_enq) begin
                exp_q.push_back(pc);
                sent++;
            end
            cyc++;
        end
        check("wrap_all_received", 64'(recv), 64'(3 * DEPTH));
        check("wrap_final_count", 64'(count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
